// File: rtl/delay_arb.sv
// delay_arb: two-requester arbiter feeding a shared fixed-latency delay line.
//
// Each cycle with en high, at most one requester is granted; its payload and
// id enter stage 0 and then shift one stage per enabled edge. The last stage
// drives the output. A cycle without a transfer pushes a zeroed bubble.
// en low freezes both the arbiter and the line.
//
// Configuration macro: DELAY_ARB_RR_EN
//   defined   -> round-robin on contention (the requester other than last_grant)
//   undefined -> fixed priority, req0 wins contention
//
// Parameters:
//   WIDTH  payload width
//   DEPTH  delay-line stages (1..8)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   en         global advance enable
//   reqN_valid requester N offers data        (N = 0, 1)
//   reqN_data  requester N payload
//   reqN_ready requester N granted this cycle (combinational)
//   out_valid  delayed item present at output
//   out_data   delayed payload, 0 when not valid
//   out_id     source requester of out_data, 0 when not valid
//   busy       any stage holds a valid item
module delay_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             busy
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("delay_arb: DEPTH must be in 1..8");
    end

    typedef struct packed {
        logic             valid;
        logic             id;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t line_q [DEPTH];
    stage_t stage_in;
    logic   gnt0;
    logic   gnt1;

`ifdef DELAY_ARB_RR_EN
    // Id of the most recent transfer; reset to 1 so the first contention goes to req0.
    logic   last_grant_q;
`endif

    // Grant decision; readys are held low during reset and while frozen.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset && en) begin
            if (req0_valid && req1_valid) begin
`ifdef DELAY_ARB_RR_EN
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Item entering stage 0: the granted payload, or an all-zero bubble.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = gnt0 | gnt1;
        stage_in.id    = gnt1;
        if (gnt1) begin
            stage_in.data = req1_data;
        end else if (gnt0) begin
            stage_in.data = req0_data;
        end
    end

    // Delay line shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                line_q[k] <= '0;
            end
        end else if (en) begin
            line_q[0] <= stage_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                line_q[k] <= line_q[k-1];
            end
        end
    end

`ifdef DELAY_ARB_RR_EN
    // Arbiter history moves only on an actual transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_grant_q <= gnt1;
        end
    end
`endif

    // Busy derives from stored valid bits only.
    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            busy = busy | line_q[k].valid;
        end
    end

    // Bubbles are zeroed, so an invalid last stage already reads as data=0, id=0.
    assign out_valid = line_q[DEPTH-1].valid;
    assign out_id    = line_q[DEPTH-1].id;
    assign out_data  = line_q[DEPTH-1].data;

endmodule

// File: tb/tb_delay_arb.sv
// Self-checking bench for delay_arb: three depths (1, 2, 8) share one stimulus
// and are compared against a slot-history reference model.
module tb_delay_arb;

    typedef struct packed {
        logic       v;
        logic       id;
        logic [7:0] d;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;

    logic       r0 [3];
    logic       r1 [3];
    logic       ov [3];
    logic       oi [3];
    logic       bz [3];
    logic [7:0] od [3];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: one slot per enabled edge since the last reset.
    item_t slots [$];
    int    cnt;
    logic  last_g;

    always #5 clk = ~clk;

    delay_arb #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .en(en),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[0]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_id(oi[0]), .busy(bz[0]));

    delay_arb #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .en(en),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[1]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_id(oi[1]), .busy(bz[1]));

    delay_arb #(.WIDTH(8), .DEPTH(8)) u_d8 (
        .clk(clk), .reset(reset), .en(en),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[2]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_id(oi[2]), .busy(bz[2]));

    function automatic int depth_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 8;
    endfunction

    // Expected output: the item accepted D enabled edges ago.
    function automatic item_t model_out(input int dep);
        int idx;
        idx = cnt - dep;
        if (idx < 0) return '0;
        return slots[idx];
    endfunction

    function automatic logic model_busy(input int dep);
        for (int k = cnt - dep; k < cnt; k++) begin
            if (k >= 0 && slots[k].v) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected grant {g1, g0} from the arbitration rules.
    function automatic logic [1:0] model_grant();
        if (!reset || !en) return 2'b00;
        if (v0 && v1) begin
`ifdef DELAY_ARB_RR_EN
            return last_g ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {v1, v0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ready(input string ph);
        logic [1:0] g;
        g = model_grant();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_d%0d_ready0", ph, depth_of(i)), 32'(r0[i]), 32'(g[0]));
            chk($sformatf("%s_d%0d_ready1", ph, depth_of(i)), 32'(r1[i]), 32'(g[1]));
        end
    endtask

    task automatic check_out(input string ph);
        item_t e;
        for (int i = 0; i < 3; i++) begin
            e = model_out(depth_of(i));
            chk($sformatf("%s_d%0d_valid", ph, depth_of(i)), 32'(ov[i]), 32'(e.v));
            chk($sformatf("%s_d%0d_data", ph, depth_of(i)), 32'(od[i]), 32'(e.d));
            chk($sformatf("%s_d%0d_id", ph, depth_of(i)), 32'(oi[i]), 32'(e.id));
            chk($sformatf("%s_d%0d_busy", ph, depth_of(i)), 32'(bz[i]),
                32'(model_busy(depth_of(i))));
        end
    endtask

    // One clock cycle: drive at negedge, check readys, advance model, check outputs.
    task automatic step(input string ph, input logic a_v0, input logic [7:0] a_d0,
                        input logic a_v1, input logic [7:0] a_d1, input logic a_en);
        logic [1:0] g;
        item_t      it;
        @(negedge clk);
        v0 = a_v0; d0 = a_d0; v1 = a_v1; d1 = a_d1; en = a_en;
        #1;
        check_ready(ph);
        g     = model_grant();
        it    = '0;
        it.v  = |g;
        it.id = g[1];
        it.d  = g[1] ? a_d1 : (g[0] ? a_d0 : 8'h00);
        @(posedge clk);
        if (reset && en) begin
            slots.push_back(it);
            cnt++;
            if (|g) last_g = g[1];
        end
        #1;
        check_out(ph);
    endtask

    task automatic model_reset();
        slots.delete();
        cnt    = 0;
        last_g = 1'b1;
    endtask

    // Mid-cycle asynchronous reset pulse spanning one rising edge.
    task automatic pulse_reset(input string ph);
        @(negedge clk);
        v0 = 1'b1; v1 = 1'b1; en = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_out({ph, "_now"});
        check_ready({ph, "_now"});
        @(posedge clk);
        #1;
        check_out({ph, "_held"});
        @(negedge clk);
        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        v0    = 1'b1;
        v1    = 1'b1;
        d0    = 8'h5A;
        d1    = 8'hC3;
        model_reset();
        #12;
        check_out("rst");
        check_ready("rst");
        @(negedge clk);
        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0;

        // Single item A5 from req0.
        step("single", 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        chk("single_d1_data", 32'(od[0]), 32'h0000_00A5);
        step("single_idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("single_d2_valid", 32'(ov[1]), 32'd1);
        chk("single_d2_data", 32'(od[1]), 32'h0000_00A5);
        chk("single_d2_id", 32'(oi[1]), 32'd0);
        for (int k = 0; k < 8; k++) step("drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("drain_d8_busy", 32'(bz[2]), 32'd0);

        // Continuous contention.
        for (int k = 0; k < 6; k++) step("contend", 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int k = 0; k < 8; k++) step("drain2", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Item 3C frozen for three cycles.
        step("freeze_in", 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) step("freeze", 1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
        for (int k = 0; k < 9; k++) step("thaw", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Two items in flight, then reset; first contention afterwards goes to req0.
        step("flight", 1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        step("flight", 1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
        pulse_reset("midrst");
        step("post_rst", 1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        chk("post_rst_d1_id", 32'(oi[0]), 32'd0);
        for (int k = 0; k < 9; k++) step("post_drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional freezes and resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
            step("rnd", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 4) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
